// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data round-robin arbiter for a single-ported memory
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Port identifiers for grant / last_grant
    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        bus_err_q, bus_err_d;
    logic        pick;
    logic [7:0]  cnt_inc;

    // Next-state logic: arbitrate in IDLE, wait for ack or timeout in BUSY, pulse ready in DONE
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        bus_err_d    = 1'b0;
        cnt_inc      = cnt_q + 8'd1;
        // On a tie the port that did not win last time is served
        pick         = (if_req && d_req) ? ~last_grant_q : (d_req ? DATA : FETCH);

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d      = BUSY;
                    grant_d      = pick;
                    last_grant_d = pick;
                    cnt_d        = 8'd0;
                    if (pick == DATA) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = 32'd0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    // An ack always beats a coincident timeout
                    state_d = DONE;
                    if (grant_q == DATA) begin
                        d_ready_d = 1'b1;
                        if (!we_q) d_rdata_d = mem_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        // Abort: complete the access with zeroed read data and flag the error
                        state_d   = DONE;
                        bus_err_d = 1'b1;
                        if (grant_q == DATA) begin
                            d_ready_d = 1'b1;
                            if (!we_q) d_rdata_d = 32'd0;
                        end else begin
                            if_ready_d = 1'b1;
                            if_rdata_d = 32'd0;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= FETCH;
            grant_q      <= FETCH;
            cnt_q        <= 8'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Memory side is driven only from the latched request registers
    always_comb begin
        mem_req   = (state_q == BUSY);
        mem_we    = (state_q == BUSY) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        if_ready  = if_ready_q;
        d_ready   = d_ready_q;
        bus_err   = bus_err_q;
        stall     = (if_req && !if_ready_q) || (d_req && !d_ready_q);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, stall, bus_err;

    int n_chk = 0;
    int n_bad = 0;

    // Model state: which port was served last, and what each port's read register should hold
    bit          lg_data;
    logic [31:0] if_rd_m, d_rd_m;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete transaction, entered and left at a falling edge with the DUT idle.
    // ack_after = number of BUSY cycles without ack before the ack; >= TO means no ack.
    task automatic do_txn(input bit fr, input bit dr, input bit dwe,
                          input logic [31:0] fa, input logic [31:0] da, input logic [31:0] dw,
                          input int ack_after, input logic [31:0] rv);
        bit wd, to;
        int nbusy;
        if_req = fr; if_addr = fa;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
        mem_ack = 1'b0;
        wd    = dr && (!fr || !lg_data);
        to    = (ack_after >= TO);
        nbusy = to ? TO : ack_after + 1;
        #1 chk("stall_req", stall, 1);
        @(negedge clk);
        chk("mem_addr", mem_addr, wd ? da : fa);
        chk("mem_wdata", mem_wdata, wd ? dw : 32'd0);
        for (int k = 0; k < nbusy; k++) begin
            chk("mem_req_busy", mem_req, 1);
            chk("mem_we_busy", mem_we, wd ? dwe : 1'b0);
            chk("rdy_busy", {if_ready, d_ready, bus_err}, 0);
            mem_ack   = (k == ack_after);
            mem_rdata = mem_ack ? rv : $urandom;
            @(negedge clk);
        end
        lg_data = wd;
        if (!(wd && dwe)) begin
            if (wd) d_rd_m = to ? 32'd0 : rv;
            else    if_rd_m = to ? 32'd0 : rv;
        end
        chk("if_ready", if_ready, !wd);
        chk("d_ready", d_ready, wd);
        chk("bus_err", bus_err, to);
        chk("mem_req_done", {mem_req, mem_we}, 0);
        chk("if_rdata", if_rdata, if_rd_m);
        chk("d_rdata", d_rdata, d_rd_m);
        chk("stall_done", stall, wd ? fr : dr);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk);
        chk("idle_out", {mem_req, if_ready, d_ready, bus_err}, 0);
        chk("if_rdata_idle", if_rdata, if_rd_m);
        chk("d_rdata_idle", d_rdata, d_rd_m);
        mem_ack = 1'b0;
    endtask

    initial begin
        bit fp, dp, dwe_r, wd;
        logic [31:0] fa, da, dw;

        reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {mem_req, mem_we, if_ready, d_ready, bus_err, stall}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        reset = 1'b0;
        lg_data = 0; if_rd_m = 0; d_rd_m = 0;

        // single fetch, ack in the first BUSY cycle
        do_txn(1, 0, 0, 32'h0040_0000, 0, 0, 0, 32'h8C02_0004);
        if_req = 0;
        // tie after reset goes to data, then fetch; then four held ties alternate D,F,D,F
        do_txn(1, 1, 0, 32'h0040_0004, 32'h1001_0000, 0, 0, 32'h1111_2222);
        do_txn(1, 0, 0, 32'h0040_0004, 32'h1001_0000, 0, 1, 32'h3333_4444);
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 0, 32'h0040_0100 + i, 32'h1001_0100 + i, 0, 0, $urandom);
        if_req = 0; d_req = 0;
        // store acked after three BUSY cycles
        do_txn(0, 1, 1, 0, 32'h1001_0008, 32'hDEAD_BEEF, 2, 32'h5555_6666);
        // fetch timeout, then a load whose ack coincides with the timeout cycle
        do_txn(1, 0, 0, 32'h0040_0200, 0, 0, TO + 3, 32'h7777_8888);
        if_req = 0;
        do_txn(0, 1, 0, 0, 32'h1001_0020, 0, TO - 1, 32'h9999_AAAA);
        // store timeout leaves d_rdata alone
        do_txn(0, 1, 1, 0, 32'h1001_0024, 32'h0BAD_F00D, TO, 32'h0);
        d_req = 0;

        // reset during the second BUSY cycle of a load
        d_req = 1; d_we = 0; d_addr = 32'h1001_0010;
        @(negedge clk);
        chk("rst_busy1", mem_req, 1);
        @(negedge clk);
        chk("rst_busy2", mem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_abort", {mem_req, d_ready, if_ready}, 0);
        reset = 1'b0; d_req = 0; mem_ack = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rst_late_ack", {mem_req, d_ready, if_ready, bus_err}, 0);
        chk("rst_late_rdata", d_rdata, 0);
        mem_ack = 0;
        lg_data = 0; if_rd_m = 0; d_rd_m = 0;

        // randomized traffic; a losing request stays held with stable operands
        fp = 0; dp = 0; fa = 0; da = 0; dw = 0; dwe_r = 0;
        for (int i = 0; i < 80; i++) begin
            if (!fp && $urandom_range(0, 1) == 1) begin
                fp = 1; fa = $urandom;
            end
            if (!dp && ($urandom_range(0, 1) == 1 || !fp)) begin
                dp = 1; da = $urandom; dw = $urandom; dwe_r = 1'($urandom_range(0, 1));
            end
            wd = dp && (!fp || !lg_data);
            do_txn(fp, dp, dwe_r, fa, da, dw, $urandom_range(0, 5), $urandom);
            if (wd) dp = 0;
            else    fp = 0;
        end
        if_req = 0; d_req = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
